frame_rx: RTL and testbench

Parametrised chip-select-framed word receiver, the next generation of the team's `rk2_var2` byte-to-word assembler. While `cs` is held low, one `W`-bit byte is sampled per clock. The first byte is a header that must equal `HDR`; it is followed by `N` payload bytes. At frame end (`cs` returns high) the block either publishes the assembled `W*N`-bit word with a one-cycle `ack`, or pulses `err` with a cause code. It sits between a parallel byte source and a word-wide consumer.

---
 rtl/frame_rx.sv | 151 +++++++++++++++
 tb/tb_frame_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
// Purpose: receives a cs-framed run of bytes (header, N payload bytes, and an
//          optional XOR checksum byte), then either publishes the assembled word
//          or reports why the frame was rejected.
// Latency: the ack/err pulse comes one clock after cs rises.
// Backpressure: none. The source paces the frame and one byte is sampled per
//               cycle while cs is low.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-low reset
//   cs     frame select, active-low
//   d_in   W-bit byte, sampled while cs=0
//   ack    one-cycle pulse when a frame is accepted (d_out updated)
//   err    one-cycle pulse when a frame is rejected
//   code   cause of the last frame: 0 ok, 1 header, 2 length, 3 checksum
//   d_out  last accepted word; the first payload byte is the MSB
//
// Optional feature: define FRAME_RX_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the payload.

module frame_rx #(
    parameter int             W   = 8,
    parameter int             N   = 2,
    parameter logic [W-1:0]   HDR = 8'hCA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [W-1:0]     d_in,
    output logic             ack,
    output logic             err,
    output logic [1:0]       code,
    output logic [W*N-1:0]   d_out
);

`ifdef FRAME_RX_CHECKSUM_EN
    localparam int LEN = N + 1;
`else
    localparam int LEN = N;
`endif
    localparam int SW = W * LEN;
    localparam int CW = $clog2(N + 3);
    localparam logic [CW-1:0] CNT_SAT = CW'(N + 2);
    localparam logic [CW-1:0] CNT_LEN = CW'(LEN);

    typedef enum logic [1:0] {
        SKIP = 2'd0,
        IDLE = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            hdr_bad;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   shreg;
`ifdef FRAME_RX_CHECKSUM_EN
    logic [W-1:0]    csum;
`endif

    logic            eval;
    logic            accept;
    logic            reject;
    logic [1:0]      code_nxt;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. SKIP waits for cs high, so the block never joins
    // a frame midway after a reset.
    always_comb begin
        state_nxt = state;
        case (state)
            SKIP:    if (cs)  state_nxt = IDLE;
            IDLE:    if (!cs) state_nxt = RECV;
            RECV:    if (cs)  state_nxt = IDLE;
            default:          state_nxt = SKIP;
        endcase
    end

    // Frame evaluation, checked in priority order: header, then length,
    // then checksum.
    always_comb begin
        eval     = (state == RECV) && cs;
        code_nxt = 2'd0;
        if (hdr_bad) begin
            code_nxt = 2'd1;
        end else if (cnt != CNT_LEN) begin
            code_nxt = 2'd2;
`ifdef FRAME_RX_CHECKSUM_EN
        end else if (csum != '0) begin
            // The checksum byte is folded into the running XOR, so a good
            // frame leaves zero.
            code_nxt = 2'd3;
`endif
        end
        accept = eval && (code_nxt == 2'd0);
        reject = eval && (code_nxt != 2'd0);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            code    <= 2'd0;
            d_out   <= '0;
            hdr_bad <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
`ifdef FRAME_RX_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            ack <= accept;
            err <= reject;
            if (eval) begin
                code <= code_nxt;
            end
            // With a checksum, the checksum byte sits in the low W bits and
            // is left out of d_out.
            if (accept) begin
                d_out <= shreg[SW-1 -: W*N];
            end
            if (state == IDLE && !cs) begin
                hdr_bad <= (d_in != HDR);
                cnt     <= '0;
`ifdef FRAME_RX_CHECKSUM_EN
                csum    <= '0;
`endif
            end else if (state == RECV && !cs) begin
                shreg <= (shreg << W) | SW'(d_in);
                // Saturating, so an overlong frame cannot wrap back to a
                // valid length.
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + 1'b1;
                end
`ifdef FRAME_RX_CHECKSUM_EN
                csum <= csum ^ d_in;
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_rx.sv
module tb_frame_rx;

    localparam int          W   = 8;
    localparam int          N   = 2;
    localparam logic [7:0]  HDR = 8'hCA;
`ifdef FRAME_RX_CHECKSUM_EN
    localparam int          LEN = N + 1;
`else
    localparam int          LEN = N;
`endif

    typedef logic [7:0] q8_t[$];

    logic            clk = 1'b0;
    logic            rst;
    logic            cs;
    logic [W-1:0]    d_in;
    logic            ack;
    logic            err;
    logic [1:0]      code;
    logic [W*N-1:0]  d_out;

    int checks   = 0;
    int failures = 0;

    // Values seen by drive_frame
    logic            res_ack, res_err, tail_ack, tail_err, lead_ack, lead_err;
    logic [1:0]      res_code;
    logic [15:0]     res_dout;
    logic [15:0]     exp_dout;

    frame_rx #(.W(W), .N(N), .HDR(HDR)) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .d_in  (d_in),
        .ack   (ack),
        .err   (err),
        .code  (code),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    // Builds a frame from a header and payload, adding the XOR checksum byte
    // when that feature is enabled.
    function automatic q8_t frame_of(input q8_t p);
        q8_t  f;
        logic [7:0] x;
        x = 8'h00;
        f.push_back(HDR);
        foreach (p[i]) begin
            f.push_back(p[i]);
            x ^= p[i];
        end
`ifdef FRAME_RX_CHECKSUM_EN
        f.push_back(x);
`endif
        return f;
    endfunction

    // Reference model: the outcome of a frame, worked out from its byte list.
    function automatic logic [1:0] model_code(input q8_t f);
        logic [7:0] x;
        if (f[0] != HDR) return 2'd1;
        if (f.size() - 1 != LEN) return 2'd2;
`ifdef FRAME_RX_CHECKSUM_EN
        x = 8'h00;
        for (int i = 1; i <= N; i++) x ^= f[i];
        if (x != f[N+1]) return 2'd3;
`else
        x = 8'h00;
`endif
        return 2'd0;
    endfunction

    function automatic logic [15:0] model_word(input q8_t f);
        logic [15:0] w;
        w = 16'h0;
        for (int i = 1; i <= N; i++) w = {w[7:0], f[i]};
        return w;
    endfunction

    // Drives a frame: drives bytes on negedges, raises cs, and records the
    // result on the negedge after the edge that samples cs high. With
    // start_now the header goes out immediately, which gives a one-cycle gap.
    task automatic drive_frame(input q8_t f, input bit start_now, input bit tail);
        for (int i = 0; i < f.size(); i++) begin
            if (i > 0 || !start_now) @(negedge clk);
            if (i == 1 && start_now) begin
                lead_ack = ack;
                lead_err = err;
            end
            cs   = 1'b0;
            d_in = f[i];
        end
        @(negedge clk);
        cs   = 1'b1;
        d_in = 8'($urandom);
        @(negedge clk);
        res_ack  = ack;
        res_err  = err;
        res_code = code;
        res_dout = d_out;
        if (tail) begin
            @(negedge clk);
            tail_ack = ack;
            tail_err = err;
        end
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        cs   = 1'b1;
        d_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (code !== 2'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
        checks++; if (d_out !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", d_out); end
        rst = 1'b1;
        @(negedge clk);
        exp_dout = 16'h0;
    endtask

    task automatic test_nominal;
        q8_t p;
        p = {8'hFF, 8'h01};
        drive_frame(frame_of(p), 1'b0, 1'b1);
        checks++; if (res_ack !== 1'b1) begin failures++; $display("FAIL nominal_ack got=%b exp=1", res_ack); end
        checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL nominal_err got=%b exp=0", res_err); end
        checks++; if (res_code !== 2'd0) begin failures++; $display("FAIL nominal_code got=%0d exp=0", res_code); end
        checks++; if (res_dout !== 16'hFF01) begin failures++; $display("FAIL nominal_dout got=%h exp=ff01", res_dout); end
        checks++; if (tail_ack !== 1'b0) begin failures++; $display("FAIL nominal_pulse_width got=%b exp=0", tail_ack); end
        exp_dout = 16'hFF01;
    endtask

    task automatic test_header;
        q8_t f;
        q8_t p;
        p = {8'h12, 8'h34};
        f = frame_of(p);
        f[0] = 8'hCC;
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_err !== 1'b1 || res_ack !== 1'b0) begin failures++; $display("FAIL hdr_pulse got=ack%b/err%b exp=ack0/err1", res_ack, res_err); end
        checks++; if (res_code !== 2'd1) begin failures++; $display("FAIL hdr_code got=%0d exp=1", res_code); end
        checks++; if (res_dout !== exp_dout) begin failures++; $display("FAIL hdr_dout got=%h exp=%h", res_dout, exp_dout); end
        checks++; if (tail_err !== 1'b0) begin failures++; $display("FAIL hdr_pulse_width got=%b exp=0", tail_err); end
    endtask

    task automatic test_length;
        q8_t f;
        f = {HDR, 8'hAB};
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_err !== 1'b1 || res_code !== 2'd2) begin failures++; $display("FAIL len_short got=err%b/code%0d exp=err1/code2", res_err, res_code); end
        checks++; if (res_dout !== exp_dout) begin failures++; $display("FAIL len_short_dout got=%h exp=%h", res_dout, exp_dout); end
`ifdef FRAME_RX_CHECKSUM_EN
        f = {HDR, 8'h11, 8'h22, 8'h33, 8'h44};
`else
        f = {HDR, 8'h11, 8'h22, 8'h33};
`endif
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_err !== 1'b1 || res_code !== 2'd2) begin failures++; $display("FAIL len_long got=err%b/code%0d exp=err1/code2", res_err, res_code); end
        checks++; if (res_ack !== 1'b0 || res_dout !== exp_dout) begin failures++; $display("FAIL len_long_dout got=%h exp=%h", res_dout, exp_dout); end
    endtask

    task automatic test_reset_midframe;
        q8_t p;
        @(negedge clk); cs = 1'b0; d_in = HDR;
        @(negedge clk); d_in = 8'h11;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (d_out !== 16'h0 || code !== 2'd0 || ack !== 1'b0 || err !== 1'b0)
            begin failures++; $display("FAIL rst_async got=dout%h/code%0d/ack%b/err%b exp=all0", d_out, code, ack, err); end
        @(negedge clk); rst = 1'b1; d_in = 8'h22;
        @(negedge clk); d_in = 8'h33;
        @(negedge clk); cs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ack !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_no_pulse got=ack%b/err%b exp=0/0", ack, err); end
        end
        checks++; if (d_out !== 16'h0 || code !== 2'd0) begin failures++; $display("FAIL rst_outputs got=dout%h/code%0d exp=0/0", d_out, code); end
        exp_dout = 16'h0;
        p = {8'h56, 8'h78};
        drive_frame(frame_of(p), 1'b0, 1'b1);
        checks++; if (res_ack !== 1'b1 || res_dout !== 16'h5678) begin failures++; $display("FAIL rst_next_frame got=ack%b/dout%h exp=1/5678", res_ack, res_dout); end
        exp_dout = 16'h5678;
    endtask

    task automatic test_back_to_back;
        q8_t p;
        logic a1;
        logic [15:0] d1;
        p = {8'h01, 8'h02};
        drive_frame(frame_of(p), 1'b0, 1'b0);
        a1 = res_ack;
        d1 = res_dout;
        p = {8'h03, 8'h04};
        drive_frame(frame_of(p), 1'b1, 1'b1);
        checks++; if (a1 !== 1'b1 || d1 !== 16'h0102) begin failures++; $display("FAIL b2b_first got=ack%b/dout%h exp=1/0102", a1, d1); end
        checks++; if (lead_ack !== 1'b0) begin failures++; $display("FAIL b2b_first_width got=%b exp=0", lead_ack); end
        checks++; if (res_ack !== 1'b1 || res_dout !== 16'h0304) begin failures++; $display("FAIL b2b_second got=ack%b/dout%h exp=1/0304", res_ack, res_dout); end
        exp_dout = 16'h0304;
    endtask

`ifdef FRAME_RX_CHECKSUM_EN
    task automatic test_checksum;
        q8_t f;
        f = {HDR, 8'h12, 8'h34, 8'h26};
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_ack !== 1'b1 || res_dout !== 16'h1234) begin failures++; $display("FAIL csum_good got=ack%b/dout%h exp=1/1234", res_ack, res_dout); end
        exp_dout = 16'h1234;
        f = {HDR, 8'h12, 8'h34, 8'h00};
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_err !== 1'b1 || res_code !== 2'd3) begin failures++; $display("FAIL csum_bad got=err%b/code%0d exp=1/3", res_err, res_code); end
        f = {HDR, 8'h12, 8'h34};
        drive_frame(f, 1'b0, 1'b1);
        checks++; if (res_err !== 1'b1 || res_code !== 2'd2) begin failures++; $display("FAIL csum_missing got=err%b/code%0d exp=1/2", res_err, res_code); end
    endtask
`endif

    task automatic test_random;
        q8_t f;
        int nb;
        logic [1:0] ec;
        logic [7:0] x;
        for (int t = 0; t < 60; t++) begin
            f = {};
            f.push_back(($urandom_range(0, 5) == 0) ? 8'($urandom) : HDR);
            nb = ($urandom_range(0, 2) != 0) ? LEN : $urandom_range(0, LEN + 2);
            x = 8'h00;
            for (int i = 0; i < nb; i++) begin
                f.push_back(8'($urandom));
                if (i < N) x ^= f[i+1];
            end
`ifdef FRAME_RX_CHECKSUM_EN
            if (nb == LEN && $urandom_range(0, 3) != 0) f[N+1] = x;
`endif
            ec = model_code(f);
            drive_frame(f, 1'($urandom_range(0, 1)), 1'b1);
            if (ec == 2'd0) exp_dout = model_word(f);
            checks++; if (res_ack !== (ec == 2'd0) || res_err !== (ec != 2'd0))
                begin failures++; $display("FAIL rand_pulse[%0d] got=ack%b/err%b exp_code=%0d", t, res_ack, res_err, ec); end
            checks++; if (res_code !== ec) begin failures++; $display("FAIL rand_code[%0d] got=%0d exp=%0d", t, res_code, ec); end
            checks++; if (res_dout !== exp_dout) begin failures++; $display("FAIL rand_dout[%0d] got=%h exp=%h", t, res_dout, exp_dout); end
            checks++; if (tail_ack !== 1'b0 || tail_err !== 1'b0) begin failures++; $display("FAIL rand_width[%0d] got=ack%b/err%b exp=0/0", t, tail_ack, tail_err); end
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_header;
        test_length;
        test_reset_midframe;
        test_back_to_back;
`ifdef FRAME_RX_CHECKSUM_EN
        test_checksum;
`endif
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
